// File: rtl/spi_clk_gen_if.sv
// Control/status bundle between the AHB register file and the SPI clock generator,
// including the event-flag channels fed back from the shift engine.
interface spi_clk_gen_if #(
   parameter int DIV_W = 16,
   parameter int CNT_W = 8,
   parameter int NCH   = 3
);
   logic [DIV_W-1:0] divclk;
   logic             cpol;
   logic [CNT_W-1:0] ncyc;
   logic             start;
   logic             abort;
   logic             sclk;
   logic             lead_stb;
   logic             trail_stb;
   logic             busy;
   logic             done;
   logic [NCH-1:0]   ev_in;
   logic [2*NCH-1:0] ev_mode;
   logic [NCH-1:0]   ev_pulse;

   modport master (
      output divclk, cpol, ncyc, start, abort, ev_in, ev_mode,
      input  sclk, lead_stb, trail_stb, busy, done, ev_pulse
   );

   modport slave (
      input  divclk, cpol, ncyc, start, abort, ev_in, ev_mode,
      output sclk, lead_stb, trail_stb, busy, done, ev_pulse
   );
endinterface

// File: rtl/spi_clk_gen.sv
// SPI clock burst generator with edge strobes, plus per-channel level-to-pulse
// event detectors with an optional synchroniser chain.
module spi_clk_gen #(
   parameter int DIV_W       = 16,
   parameter int CNT_W       = 8,
   parameter int NCH         = 3,
   parameter int SYNC_STAGES = 0
) (
   input  logic         clk,
   input  logic         rst,
   spi_clk_gen_if.slave bus
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] cnt, cnt_nxt, div_l, div_nxt;
   logic [CNT_W-1:0] ecnt, ecnt_nxt, ncyc_l, ncyc_nxt;
   logic             cpol_l, cpol_nxt;
   logic             sclk_q, sclk_nxt;
   logic             lead_q, lead_nxt;
   logic             trail_q, trail_nxt;
   logic             busy_q, busy_nxt;
   logic             done_q, done_nxt;

   function automatic logic ev_detect(input logic s, input logic h, input logic [1:0] mode);
      case (mode)
         2'b00:   return s & ~h;
         2'b01:   return ~s & h;
         2'b10:   return s ^ h;
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ecnt_nxt  = ecnt;
      div_nxt   = div_l;
      ncyc_nxt  = ncyc_l;
      cpol_nxt  = cpol_l;
      sclk_nxt  = sclk_q;
      lead_nxt  = 1'b0;
      trail_nxt = 1'b0;
      busy_nxt  = busy_q;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            sclk_nxt = bus.cpol;
            cnt_nxt  = '0;
            busy_nxt = 1'b0;
            if (bus.start && !bus.abort) begin
               if (bus.ncyc != '0) begin
                  div_nxt   = bus.divclk;
                  cpol_nxt  = bus.cpol;
                  ncyc_nxt  = bus.ncyc;
                  ecnt_nxt  = '0;
                  busy_nxt  = 1'b1;
                  state_nxt = RUN;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_nxt = IDLE;
               busy_nxt  = 1'b0;
               sclk_nxt  = cpol_l;
               cnt_nxt   = '0;
            end else if (cnt == div_l) begin
               cnt_nxt  = '0;
               sclk_nxt = ~sclk_q;
               // Leaving the idle level is a leading edge; returning to it ends one SCLK cycle.
               if (~sclk_q != cpol_l) begin
                  lead_nxt = 1'b1;
               end else begin
                  trail_nxt = 1'b1;
                  ecnt_nxt  = ecnt + CNT_W'(1);
                  if (ecnt_nxt == ncyc_l) begin
                     state_nxt = IDLE;
                     busy_nxt  = 1'b0;
                     done_nxt  = 1'b1;
                  end
               end
            end else begin
               cnt_nxt = cnt + DIV_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         ecnt    <= '0;
         div_l   <= '0;
         ncyc_l  <= '0;
         cpol_l  <= 1'b0;
         sclk_q  <= 1'b0;
         lead_q  <= 1'b0;
         trail_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         ecnt    <= ecnt_nxt;
         div_l   <= div_nxt;
         ncyc_l  <= ncyc_nxt;
         cpol_l  <= cpol_nxt;
         sclk_q  <= sclk_nxt;
         lead_q  <= lead_nxt;
         trail_q <= trail_nxt;
         busy_q  <= busy_nxt;
         done_q  <= done_nxt;
      end
   end

   assign bus.sclk      = sclk_q;
   assign bus.lead_stb  = lead_q;
   assign bus.trail_stb = trail_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

   logic [NCH-1:0] ev_s, ev_h, ev_pulse_q;

   // Synchroniser stage p0 takes the raw flags; the last stage feeds the edge detector.
   if (SYNC_STAGES > 0) begin : g_sync
      logic [NCH-1:0] sync_p [SYNC_STAGES];
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int j = 0; j < SYNC_STAGES; j++) sync_p[j] <= '0;
         end else begin
            sync_p[0] <= bus.ev_in;
            for (int j = 1; j < SYNC_STAGES; j++) sync_p[j] <= sync_p[j-1];
         end
      end
      assign ev_s = sync_p[SYNC_STAGES-1];
   end else begin : g_nosync
      assign ev_s = bus.ev_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ev_h       <= '0;
         ev_pulse_q <= '0;
      end else begin
         ev_h <= ev_s;
         for (int i = 0; i < NCH; i++)
            ev_pulse_q[i] <= ev_detect(ev_s[i], ev_h[i], bus.ev_mode[2*i +: 2]);
      end
   end

   assign bus.ev_pulse = ev_pulse_q;

endmodule

// File: tb/tb_spi_clk_gen.sv
// Directed bench for spi_clk_gen: SCLK bursts, abort/start corner cases and
// synchronised event pulses (SYNC_STAGES=2, four channels: rise/fall/both/off).
module tb_spi_clk_gen;
   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   spi_clk_gen_if #(.DIV_W(16), .CNT_W(8), .NCH(4)) bus ();

   spi_clk_gen #(.DIV_W(16), .CNT_W(8), .NCH(4), .SYNC_STAGES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output vector order: {sclk, lead_stb, trail_stb, busy, done}
   task automatic chk_o(input string tag, input logic [4:0] exp_v);
      logic [4:0] obs;
      obs = {bus.sclk, bus.lead_stb, bus.trail_stb, bus.busy, bus.done};
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
   endtask

   task automatic chk_e(input string tag, input logic [3:0] exp_v);
      logic [3:0] obs;
      obs = bus.ev_pulse;
      n_cmp++;
      assert (obs === exp_v) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
      end
   endtask

   initial begin
      rst         = 1'b1;
      bus.divclk  = '0;
      bus.cpol    = 1'b0;
      bus.ncyc    = '0;
      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.ev_in   = 4'b0000;
      bus.ev_mode = 8'b11_10_01_00;
      tick();
      tick();
      chk_o("reset_out", 5'b00000);
      chk_e("reset_ev", 4'b0000);
      rst = 1'b0;
      tick();

      // divclk=0, ncyc=2, cpol=0
      bus.divclk = 16'd0; bus.ncyc = 8'd2; bus.cpol = 1'b0; bus.start = 1'b1;
      tick(); chk_o("b1_k0", 5'b00010);
      bus.start = 1'b0;
      tick(); chk_o("b1_k1", 5'b11010);
      tick(); chk_o("b1_k2", 5'b00110);
      tick(); chk_o("b1_k3", 5'b11010);
      tick(); chk_o("b1_k4", 5'b00101);
      tick(); chk_o("b1_k5", 5'b00000);

      // divclk=3, ncyc=1, cpol=1; inputs changed and start re-issued mid-burst
      bus.cpol = 1'b1;
      tick(); chk_o("b2_idle_cpol", 5'b10000);
      bus.divclk = 16'd3; bus.ncyc = 8'd1; bus.start = 1'b1;
      tick(); chk_o("b2_k0", 5'b10010);
      bus.start = 1'b0; bus.divclk = 16'd0; bus.ncyc = 8'd5; bus.cpol = 1'b0;
      tick(); chk_o("b2_k1", 5'b10010);
      bus.start = 1'b1;
      tick(); chk_o("b2_k2", 5'b10010);
      bus.start = 1'b0;
      tick(); chk_o("b2_k3", 5'b10010);
      tick(); chk_o("b2_k4_lead", 5'b01010);
      for (int i = 0; i < 3; i++) begin
         tick(); chk_o("b2_low", 5'b00010);
      end
      tick(); chk_o("b2_k8_trail_done", 5'b10101);
      tick(); chk_o("b2_k9_idle", 5'b00000);

      // abort during divclk=2, ncyc=4 burst
      bus.divclk = 16'd2; bus.ncyc = 8'd4; bus.start = 1'b1;
      tick(); chk_o("ab_k0", 5'b00010);
      bus.start = 1'b0;
      tick(); chk_o("ab_k1", 5'b00010);
      tick(); chk_o("ab_k2", 5'b00010);
      tick(); chk_o("ab_k3", 5'b11010);
      tick(); chk_o("ab_k4", 5'b10010);
      bus.abort = 1'b1;
      tick(); chk_o("ab_k5", 5'b00000);
      bus.abort = 1'b0;
      tick(); chk_o("ab_no_done", 5'b00000);

      // restart after abort, divclk=0, ncyc=1
      bus.divclk = 16'd0; bus.ncyc = 8'd1; bus.start = 1'b1;
      tick(); chk_o("rs_k0", 5'b00010);
      bus.start = 1'b0;
      tick(); chk_o("rs_k1", 5'b11010);
      tick(); chk_o("rs_k2", 5'b00101);
      tick(); chk_o("rs_k3", 5'b00000);

      // abort coincides with terminal trailing edge
      bus.start = 1'b1;
      tick(); chk_o("at_k0", 5'b00010);
      bus.start = 1'b0;
      tick(); chk_o("at_k1", 5'b11010);
      bus.abort = 1'b1;
      tick(); chk_o("at_k2", 5'b00000);
      bus.abort = 1'b0;
      tick(); chk_o("at_k3", 5'b00000);

      // ncyc=0 start, then start+abort together
      bus.ncyc = 8'd0; bus.start = 1'b1;
      tick(); chk_o("z_done", 5'b00001);
      bus.start = 1'b0;
      tick(); chk_o("z_after", 5'b00000);
      bus.ncyc = 8'd2; bus.start = 1'b1; bus.abort = 1'b1;
      tick(); chk_o("sa_k0", 5'b00000);
      bus.start = 1'b0; bus.abort = 1'b0;
      tick(); chk_o("sa_k1", 5'b00000);

      // events: rise seen on ch0/ch2, fall on ch1/ch2, ch3 disabled
      bus.ev_in = 4'b1111;
      tick(); chk_e("ev_r0", 4'b0000);
      tick(); chk_e("ev_r1", 4'b0000);
      tick(); chk_e("ev_r2", 4'b0101);
      tick(); chk_e("ev_r3", 4'b0000);
      tick(); chk_e("ev_r4", 4'b0000);
      bus.ev_in = 4'b0000;
      tick(); chk_e("ev_f0", 4'b0000);
      tick(); chk_e("ev_f1", 4'b0000);
      tick(); chk_e("ev_f2", 4'b0110);
      tick(); chk_e("ev_f3", 4'b0000);

      // reset mid-burst with event inputs held high
      bus.divclk = 16'd0; bus.ncyc = 8'd3; bus.start = 1'b1;
      tick(); chk_o("rb_k0", 5'b00010);
      bus.start = 1'b0;
      tick(); chk_o("rb_k1", 5'b11010);
      rst = 1'b1; bus.ev_in = 4'b1111;
      tick(); chk_o("rb_rst0", 5'b00000); chk_e("rb_rst0_ev", 4'b0000);
      tick(); chk_o("rb_rst1", 5'b00000); chk_e("rb_rst1_ev", 4'b0000);
      rst = 1'b0;
      tick(); chk_o("rb_m0", 5'b00000); chk_e("rb_m0_ev", 4'b0000);
      tick(); chk_e("rb_m1_ev", 4'b0000);
      tick(); chk_e("rb_m2_ev", 4'b0101);
      tick(); chk_e("rb_m3_ev", 4'b0000);
      chk_o("rb_m3_out", 5'b00000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
